// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between NUM_REQ producers.
// Each grant is a bounded burst that ends on last, on the burst cap, or when the owner drops req.
module fifo_write_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            last,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            ack,
    output logic                          fifo_we,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    input  logic                          fifo_full,
    output logic                          busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;

    logic               win_found;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic               active;
    logic               owner_req;
    logic               owner_last;
    logic               accept;

    // Rotating priority scan starting just after the previous winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = PTR_W'((32'(ptr_q) + i) % NUM_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Write-port decode keys off the registered grant so reset drops it immediately.
    always_comb begin
        active     = |grant_q;
        owner_req  = active & req[ptr_q];
        owner_last = last[ptr_q];
        accept     = owner_req & ~fifo_full;
        ack        = accept ? grant_q : '0;
        fifo_we    = accept;
        fifo_data  = active ? data_i[32'(ptr_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BURST;
                    grant_d = NUM_REQ'(1) << win_idx;
                    ptr_d   = win_idx;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                if (!owner_req || (accept && (owner_last || cnt_q == CNT_LAST))) begin
                    state_d = IDLE;
                    grant_d = '0;
                    cnt_d   = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == BURST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= PTR_RST;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a burst-level reference model.
module tb_fifo_write_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned MB = 8;

    logic              clk;
    logic              rst;
    logic [NR-1:0]     req;
    logic [NR-1:0]     last;
    logic [NR*DW-1:0]  data_i;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     ack;
    logic              fifo_we;
    logic [DW-1:0]     fifo_data;
    logic              fifo_full;
    logic              busy;

    fifo_write_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .last     (last),
        .data_i   (data_i),
        .grant    (grant),
        .ack      (ack),
        .fifo_we  (fifo_we),
        .fifo_data(fifo_data),
        .fifo_full(fifo_full),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: current owner (-1 = none), last winner, words in burst.
    int m_owner;
    int m_ptr;
    int m_cnt;

    logic [NR-1:0]    s_req, s_last;
    logic             s_full;
    logic [NR*DW-1:0] s_data;
    logic [NR-1:0]    o_grant, o_ack;
    logic             o_we, o_busy;
    logic [DW-1:0]    o_data;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = NR - 1;
        m_cnt   = 0;
    endtask

    // Drive inputs, let combinational outputs settle, compare against the model.
    task automatic drive_check(input logic [NR-1:0] r, input logic [NR-1:0] l,
                               input logic [NR*DW-1:0] d, input logic f);
        logic [NR-1:0] e_grant, e_ack;
        logic          e_we;
        logic [DW-1:0] e_data;
        req = r; last = l; data_i = d; fifo_full = f;
        s_req = r; s_last = l; s_data = d; s_full = f;
        #4;
        o_grant = grant; o_ack = ack; o_we = fifo_we; o_busy = busy; o_data = fifo_data;
        e_grant = '0; e_ack = '0; e_we = 1'b0; e_data = '0;
        if (m_owner >= 0) begin
            e_grant = NR'(1) << m_owner;
            e_data  = s_data[m_owner*DW +: DW];
            if (s_req[m_owner] && !s_full) begin
                e_we  = 1'b1;
                e_ack = e_grant;
            end
        end
        check_eq("model_grant", 64'(o_grant), 64'(e_grant));
        check_eq("model_ack",   64'(o_ack),   64'(e_ack));
        check_eq("model_we",    64'(o_we),    64'(e_we));
        check_eq("model_data",  64'(o_data),  64'(e_data));
        check_eq("model_busy",  64'(o_busy),  64'(m_owner >= 0));
    endtask

    task automatic advance();
        bit acc;
        bit found;
        if (m_owner < 0) begin
            found = 0;
            for (int i = 1; i <= int'(NR); i++) begin
                int k;
                k = (m_ptr + i) % NR;
                if (!found && s_req[k]) begin
                    found   = 1;
                    m_owner = k;
                    m_ptr   = k;
                    m_cnt   = 0;
                end
            end
        end else begin
            acc = s_req[m_owner] && !s_full;
            if (!s_req[m_owner] || (acc && (s_last[m_owner] || m_cnt == MB - 1))) begin
                m_owner = -1;
                m_cnt   = 0;
            end else if (acc) begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] l,
                        input logic [NR*DW-1:0] d, input logic f);
        drive_check(r, l, d, f);
        advance();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '1; last = '1; data_i = {NR{32'hDEAD_BEEF}}; fifo_full = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_grant", 64'(grant),     64'd0);
        check_eq("rst_busy",  64'(busy),      64'd0);
        check_eq("rst_we",    64'(fifo_we),   64'd0);
        check_eq("rst_ack",   64'(ack),       64'd0);
        check_eq("rst_data",  64'(fifo_data), 64'd0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [3:0]       rr_exp [5];
        logic [NR*DW-1:0] d;
        logic             p_req  [NR];
        logic             p_last [NR];
        logic [DW-1:0]    p_data [NR];
        logic [NR-1:0]    r, l;
        logic             f;
        int               w, st;
        bit               chk_end;
        int               tw[$];
        logic [NR-1:0]    gh [64];

        rst = 1'b1;
        req = '0; last = '0; data_i = '0; fifo_full = 1'b0;
        model_reset();

        // Reset and single word
        do_reset();
        d = '0; d[DW-1:0] = 32'hA5A5_0001;
        step(4'b0001, 4'b0001, d, 1'b0);
        check_eq("single_c0_grant", 64'(o_grant), 64'd0);
        step(4'b0001, 4'b0001, d, 1'b0);
        check_eq("single_grant", 64'(o_grant), 64'b0001);
        check_eq("single_we",    64'(o_we),    64'd1);
        check_eq("single_data",  64'(o_data),  64'hA5A5_0001);
        check_eq("single_ack",   64'(o_ack),   64'b0001);
        step(4'b0000, 4'b0000, d, 1'b0);
        check_eq("single_end_grant", 64'(o_grant), 64'd0);
        check_eq("single_end_busy",  64'(o_busy),  64'd0);

        // Round-robin with everyone requesting single-word packets
        do_reset();
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step(4'b1111, 4'b1111, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0);
            if (c % 2 == 1) check_eq("rr_grant", 64'(o_grant), 64'(rr_exp[c/2]));
            else            check_eq("rr_idle",  64'(o_grant), 64'd0);
        end

        // Burst cap: requester 2 streams 12 words without last
        do_reset();
        w = 0;
        tw.delete();
        for (int c = 0; c < 40; c++) begin
            r = (w < 12) ? 4'b0100 : 4'b0000;
            d = '0; d[2*DW +: DW] = DW'(w);
            step(r, 4'b0000, d, 1'b0);
            gh[c] = o_grant;
            if (o_we) begin
                check_eq("cap_word", 64'(o_data), 64'(w));
                tw.push_back(c);
                w++;
            end
        end
        check_eq("cap_count", 64'(w), 64'd12);
        if (tw.size() == 12) begin
            check_eq("cap_first_run", 64'(tw[7] - tw[0]), 64'd7);
            check_eq("cap_gap",       64'(tw[8] - tw[7]), 64'd2);
            check_eq("cap_gap_grant", 64'(gh[tw[7] + 1]), 64'd0);
            check_eq("cap_regrant",   64'(gh[tw[8]]),     64'b0100);
        end

        // Full stall at cnt=3 for 5 cycles
        do_reset();
        w = 0; st = 0; chk_end = 0;
        for (int c = 0; c < 40; c++) begin
            f = (w == 3 && st < 5);
            r = (w < 10) ? 4'b0010 : 4'b0000;
            d = '0; d[DW +: DW] = DW'(w + 1);
            step(r, 4'b0000, d, f);
            if (f) begin
                check_eq("stall_ack",   64'(o_ack),   64'd0);
                check_eq("stall_we",    64'(o_we),    64'd0);
                check_eq("stall_grant", 64'(o_grant), 64'b0010);
                st++;
            end else if (w == 3 && st == 5) begin
                check_eq("stall_release_we",   64'(o_we),   64'd1);
                check_eq("stall_release_data", 64'(o_data), 64'd4);
            end
            if (chk_end) begin
                check_eq("stall_burst_end", 64'(o_grant), 64'd0);
                chk_end = 0;
            end
            if (o_we) begin
                w++;
                if (w == 8) chk_end = 1;
            end
        end
        check_eq("stall_cycles", 64'(st), 64'd5);

        // Owner drop with requester 3 pending
        do_reset();
        d = {32'h3333_0000, 32'h2222_0000, 32'h1111_0000, 32'h0};
        step(4'b0010, 4'b0000, d, 1'b0);
        step(4'b1010, 4'b0000, d, 1'b0);
        check_eq("drop_w1", 64'(o_we), 64'd1);
        step(4'b1010, 4'b0000, d, 1'b0);
        check_eq("drop_w2", 64'(o_we), 64'd1);
        step(4'b1000, 4'b0000, d, 1'b0);
        check_eq("drop_nowrite", 64'(o_we), 64'd0);
        step(4'b1000, 4'b0000, d, 1'b0);
        check_eq("drop_idle", 64'(o_grant), 64'd0);
        step(4'b1000, 4'b0000, d, 1'b0);
        check_eq("drop_next_owner", 64'(o_grant), 64'b1000);
        step(4'b0000, 4'b0000, d, 1'b0);

        // Asynchronous reset while a write is in progress
        do_reset();
        d = {32'h4, 32'h3, 32'h2, 32'h1};
        step(4'b1111, 4'b0000, d, 1'b0);
        drive_check(4'b1111, 4'b0000, d, 1'b0);
        check_eq("mrst_we_before", 64'(o_we), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("mrst_we",    64'(fifo_we), 64'd0);
        check_eq("mrst_ack",   64'(ack),     64'd0);
        check_eq("mrst_grant", 64'(grant),   64'd0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        step(4'b1111, 4'b0000, d, 1'b0);
        check_eq("mrst_idle", 64'(o_grant), 64'd0);
        step(4'b1111, 4'b0000, d, 1'b0);
        check_eq("mrst_first_grant", 64'(o_grant), 64'b0001);
        step(4'b0000, 4'b0000, d, 1'b0);

        // Randomized traffic: producers hold each word until acked, occasionally withdraw
        do_reset();
        for (int k = 0; k < int'(NR); k++) begin
            p_req[k] = 0; p_last[k] = 0; p_data[k] = '0;
        end
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < int'(NR); k++) begin
                if (!p_req[k]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        p_req[k]  = 1;
                        p_data[k] = $urandom;
                        p_last[k] = ($urandom_range(0, 3) == 0);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    p_req[k] = 0;
                end
                r[k] = p_req[k];
                l[k] = p_req[k] ? p_last[k] : 1'($urandom_range(0, 1));
                d[k*DW +: DW] = p_data[k];
            end
            f = ($urandom_range(0, 3) == 0);
            step(r, l, d, f);
            for (int k = 0; k < int'(NR); k++)
                if (o_ack[k]) p_req[k] = 0;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
